mem_port_arbiter: RTL and testbench

- Single-port arbiter and sequencer in front of the unified instruction/data memory.
- Three requesters share the memory port:
  - the SREC boot loader (writes only);
  - the fetch unit (instruction reads);
  - the data-access path (loads and stores).
- Owns the boot-to-run transition: fetch is stalled until the loader signals completion, then fetch and data requests are arbitrated with anti-starvation for fetch.

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single memory port shared by the SREC boot loader, the
// fetch unit and the data-access path. Holds fetch off until the loader is
// done, then arbitrates fetch against data with a starvation guard for fetch.
// Every output is a register; grant/rvalid/write strobes are one-cycle pulses.
module mem_port_arbiter #(
  parameter int unsigned RD_LAT     = 1,  // grant edge to read-data sample edge (1..7)
  parameter int unsigned STARVE_LIM = 4   // lost arbitrations before fetch is forced (1..15)
) (
  input  logic        clk,
  input  logic        rst_n,
  // boot loader (write only)
  input  logic        boot_req_in,
  input  logic [31:0] boot_addr_in,
  input  logic [31:0] boot_data_in,
  input  logic [1:0]  boot_size_in,
  input  logic        boot_done_in,
  output logic        boot_gnt_out,
  // fetch unit (read only)
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  input  logic [1:0]  if_size_in,
  output logic        if_gnt_out,
  output logic        if_rvalid_out,
  output logic [31:0] if_rdata_out,
  // data-access path (loads and stores)
  input  logic        d_req_in,
  input  logic        d_we_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [1:0]  d_size_in,
  output logic        d_gnt_out,
  output logic        d_rvalid_out,
  output logic [31:0] d_rdata_out,
  // memory port
  output logic [31:0] mem_address_out,
  output logic [31:0] mem_data_out,
  output logic        mem_write_out,
  output logic [1:0]  mem_access_size_out,
  input  logic [31:0] mem_data_in,
  // pipeline control
  output logic        fetch_stall_out
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    TURN    = 2'd2,
    WAIT_RD = 2'd3
  } state_t;

  localparam logic [2:0] LAT_INIT   = 3'(RD_LAT);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  state_t      state_reg;
  logic [2:0]  lat_cnt_reg;        // edges left until read data is sampled
  logic [3:0]  starve_cnt_reg;     // consecutive arbitrations fetch has lost
  logic        turn_to_run_reg;    // TURN returns to RUN (1) or BOOT (0)
  logic        owner_is_data_reg;  // which requester owns the outstanding read

  logic        fetch_wins;
  logic        data_wins;

  // RUN-state arbitration: fetch takes the port when data is idle or when it
  // has been passed over STARVE_LIM times in a row.
  always_comb begin
    fetch_wins = if_req_in && (!d_req_in || (starve_cnt_reg == STARVE_MAX));
    data_wins  = d_req_in && !fetch_wins;
  end

  // Sequencer: boot writes, run-time arbitration, write turnaround and read wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg           <= BOOT;
      lat_cnt_reg         <= '0;
      starve_cnt_reg      <= '0;
      turn_to_run_reg     <= 1'b0;
      owner_is_data_reg   <= 1'b0;
      boot_gnt_out        <= 1'b0;
      if_gnt_out          <= 1'b0;
      if_rvalid_out       <= 1'b0;
      if_rdata_out        <= '0;
      d_gnt_out           <= 1'b0;
      d_rvalid_out        <= 1'b0;
      d_rdata_out         <= '0;
      mem_address_out     <= '0;
      mem_data_out        <= '0;
      mem_write_out       <= 1'b0;
      mem_access_size_out <= '0;
      fetch_stall_out     <= 1'b1;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      boot_gnt_out  <= 1'b0;
      if_gnt_out    <= 1'b0;
      d_gnt_out     <= 1'b0;
      if_rvalid_out <= 1'b0;
      d_rvalid_out  <= 1'b0;
      mem_write_out <= 1'b0;

      // A fetch unit that is not asking cannot be starving.
      if (!if_req_in) begin
        starve_cnt_reg <= '0;
      end

      case (state_reg)
        BOOT: begin
          if (boot_req_in) begin
            boot_gnt_out        <= 1'b1;
            mem_address_out     <= boot_addr_in;
            mem_data_out        <= boot_data_in;
            mem_access_size_out <= boot_size_in;
            mem_write_out       <= 1'b1;
            turn_to_run_reg     <= 1'b0;
            state_reg           <= TURN;
          end else if (boot_done_in) begin
            fetch_stall_out <= 1'b0;
            state_reg       <= RUN;
          end
        end

        RUN: begin
          if (fetch_wins) begin
            if_gnt_out          <= 1'b1;
            mem_address_out     <= if_addr_in;
            mem_access_size_out <= if_size_in;
            starve_cnt_reg      <= '0;
            owner_is_data_reg   <= 1'b0;
            lat_cnt_reg         <= LAT_INIT;
            state_reg           <= WAIT_RD;
          end else if (data_wins) begin
            d_gnt_out           <= 1'b1;
            mem_address_out     <= d_addr_in;
            mem_access_size_out <= d_size_in;
            if (if_req_in && (starve_cnt_reg < STARVE_MAX)) begin
              starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end
            if (d_we_in) begin
              mem_data_out    <= d_wdata_in;
              mem_write_out   <= 1'b1;
              turn_to_run_reg <= 1'b1;
              state_reg       <= TURN;
            end else begin
              owner_is_data_reg <= 1'b1;
              lat_cnt_reg       <= LAT_INIT;
              state_reg         <= WAIT_RD;
            end
          end
        end

        TURN: begin
          // Idle slot so the requester can drop req after seeing its grant.
          state_reg <= turn_to_run_reg ? RUN : BOOT;
        end

        WAIT_RD: begin
          if (lat_cnt_reg <= 3'd1) begin
            lat_cnt_reg <= '0;
            if (owner_is_data_reg) begin
              d_rdata_out  <= mem_data_in;
              d_rvalid_out <= 1'b1;
            end else begin
              if_rdata_out  <= mem_data_in;
              if_rvalid_out <= 1'b1;
            end
            state_reg <= RUN;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 3'd1;
          end
        end

        default: state_reg <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a timestamp-based model of the port schedule is
// checked against every DUT output one step after each rising edge, and
// directed scenarios pin grant spacing, latency, starvation and reset.
module tb_mem_port_arbiter;

  localparam int RD_LAT     = 2;
  localparam int STARVE_LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_req_in, boot_done_in;
  logic [31:0] boot_addr_in, boot_data_in;
  logic [1:0]  boot_size_in;
  logic        boot_gnt_out;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic [1:0]  if_size_in;
  logic        if_gnt_out, if_rvalid_out;
  logic [31:0] if_rdata_out;
  logic        d_req_in, d_we_in;
  logic [31:0] d_addr_in, d_wdata_in;
  logic [1:0]  d_size_in;
  logic        d_gnt_out, d_rvalid_out;
  logic [31:0] d_rdata_out;
  logic [31:0] mem_address_out, mem_data_out, mem_data_in;
  logic        mem_write_out;
  logic [1:0]  mem_access_size_out;
  logic        fetch_stall_out;

  mem_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .boot_req_in(boot_req_in), .boot_addr_in(boot_addr_in),
    .boot_data_in(boot_data_in), .boot_size_in(boot_size_in),
    .boot_done_in(boot_done_in), .boot_gnt_out(boot_gnt_out),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_size_in(if_size_in),
    .if_gnt_out(if_gnt_out), .if_rvalid_out(if_rvalid_out), .if_rdata_out(if_rdata_out),
    .d_req_in(d_req_in), .d_we_in(d_we_in), .d_addr_in(d_addr_in),
    .d_wdata_in(d_wdata_in), .d_size_in(d_size_in), .d_gnt_out(d_gnt_out),
    .d_rvalid_out(d_rvalid_out), .d_rdata_out(d_rdata_out),
    .mem_address_out(mem_address_out), .mem_data_out(mem_data_out),
    .mem_write_out(mem_write_out), .mem_access_size_out(mem_access_size_out),
    .mem_data_in(mem_data_in), .fetch_stall_out(fetch_stall_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Memory seen by the DUT (updated from its write strobe) and the model's
  // own memory image (updated from the writes the model expects).
  logic [31:0] tb_mem    [0:8191];
  logic [31:0] model_mem [0:8191];
  assign mem_data_in = tb_mem[mem_address_out[12:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model (edge timestamps, not states) -------
  int          m_edge, m_next_arb, m_rd_due, m_losses;
  bit          m_in_boot, m_rd_data;
  logic        e_boot_gnt, e_if_gnt, e_d_gnt, e_if_rvalid, e_d_rvalid, e_write, e_stall;
  logic [31:0] e_if_rdata, e_d_rdata, e_addr, e_wdata;
  logic [1:0]  e_size;

  task automatic model_reset();
    m_edge = 0; m_next_arb = 1; m_rd_due = -1; m_losses = 0;
    m_in_boot = 1'b1; m_rd_data = 1'b0;
    e_boot_gnt = 0; e_if_gnt = 0; e_d_gnt = 0; e_if_rvalid = 0; e_d_rvalid = 0;
    e_write = 0; e_stall = 1; e_if_rdata = 0; e_d_rdata = 0; e_addr = 0; e_wdata = 0; e_size = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_edge++;
    e_boot_gnt = 0; e_if_gnt = 0; e_d_gnt = 0; e_if_rvalid = 0; e_d_rvalid = 0; e_write = 0;
    if (m_edge == m_rd_due) begin
      if (m_rd_data) begin e_d_rvalid = 1; e_d_rdata = model_mem[e_addr[12:0]]; end
      else begin e_if_rvalid = 1; e_if_rdata = model_mem[e_addr[12:0]]; end
      m_rd_due = -1;
    end
    if (m_edge >= m_next_arb) begin
      if (m_in_boot) begin
        if (boot_req_in) begin
          e_boot_gnt = 1; e_write = 1;
          e_addr = boot_addr_in; e_wdata = boot_data_in; e_size = boot_size_in;
          model_mem[boot_addr_in[12:0]] = boot_data_in;
          m_next_arb = m_edge + 2;
        end else if (boot_done_in) begin
          m_in_boot = 0; e_stall = 0;
        end
      end else if (if_req_in && (!d_req_in || m_losses == STARVE_LIM)) begin
        e_if_gnt = 1; e_addr = if_addr_in; e_size = if_size_in;
        m_rd_data = 0; m_rd_due = m_edge + RD_LAT; m_next_arb = m_edge + RD_LAT + 1;
        m_losses = 0;
      end else if (d_req_in) begin
        e_d_gnt = 1; e_addr = d_addr_in; e_size = d_size_in;
        if (if_req_in && m_losses < STARVE_LIM) m_losses++;
        if (d_we_in) begin
          e_write = 1; e_wdata = d_wdata_in;
          model_mem[d_addr_in[12:0]] = d_wdata_in;
          m_next_arb = m_edge + 2;
        end else begin
          m_rd_data = 1; m_rd_due = m_edge + RD_LAT; m_next_arb = m_edge + RD_LAT + 1;
        end
      end
    end
    if (!if_req_in) m_losses = 0;
  endtask

  task automatic compare_all();
    check("boot_gnt", boot_gnt_out, e_boot_gnt);
    check("if_gnt", if_gnt_out, e_if_gnt);
    check("d_gnt", d_gnt_out, e_d_gnt);
    check("if_rvalid", if_rvalid_out, e_if_rvalid);
    check("d_rvalid", d_rvalid_out, e_d_rvalid);
    check("if_rdata", if_rdata_out, e_if_rdata);
    check("d_rdata", d_rdata_out, e_d_rdata);
    check("mem_address", mem_address_out, e_addr);
    check("mem_data", mem_data_out, e_wdata);
    check("mem_write", mem_write_out, e_write);
    check("mem_size", mem_access_size_out, e_size);
    check("fetch_stall", fetch_stall_out, e_stall);
  endtask

  // Model/compare process; also owns the DUT-side memory image.
  initial begin
    for (int i = 0; i < 8192; i++) begin
      tb_mem[i]    = 32'hC0DE_0000 | 32'(i);
      model_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    tb_mem[13'h0004]    = 32'h27BD_FFE8;
    model_mem[13'h0004] = 32'h27BD_FFE8;
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      compare_all();
      if (mem_write_out) tb_mem[mem_address_out[12:0]] = mem_data_out;
      if (boot_gnt_out) $display("txn cyc=%0d boot write addr=%08h data=%08h", cyc, mem_address_out, mem_data_out);
      if (if_gnt_out)   $display("txn cyc=%0d fetch read addr=%08h", cyc, mem_address_out);
      if (d_gnt_out)    $display("txn cyc=%0d data %s addr=%08h", cyc, mem_write_out ? "store" : "load", mem_address_out);
      if (if_rvalid_out) $display("txn cyc=%0d fetch rdata=%08h", cyc, if_rdata_out);
      if (d_rvalid_out)  $display("txn cyc=%0d load rdata=%08h", cyc, d_rdata_out);
    end
  end

  // ---------------- directed stimulus -------------------------------------
  function automatic logic sig(input int which);
    case (which)
      0: return boot_gnt_out;
      1: return if_gnt_out;
      2: return d_gnt_out;
      3: return if_rvalid_out;
      4: return d_rvalid_out;
      default: return if_gnt_out | d_gnt_out;
    endcase
  endfunction

  // Waits (bounded) for the selected pulse, observed on a falling edge.
  task automatic wait_for(input int which, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sig(which)) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: signal %0d never pulsed (cycle %0d)", which, cyc);
    end
  endtask

  logic [31:0] bdata [3];
  int t, tprev, tf, tr, td;
  logic [9:0] pat;

  initial begin
    bdata[0] = 32'h0000_00AA; bdata[1] = 32'h0000_00BB; bdata[2] = 32'h0000_00CC;
    rst_n = 0; boot_req_in = 0; boot_done_in = 0; boot_addr_in = 0; boot_data_in = 0;
    boot_size_in = 0; if_req_in = 0; if_addr_in = 0; if_size_in = 0;
    d_req_in = 0; d_we_in = 0; d_addr_in = 0; d_wdata_in = 0; d_size_in = 0;
    tprev = 0;
    repeat (2) @(negedge clk);
    check("reset_stall", fetch_stall_out, 1);
    check("reset_addr", mem_address_out, 0);
    rst_n = 1;

    // Boot load; fetch asks throughout but must not be served. Last write
    // arrives together with boot_done.
    if_req_in = 1; if_addr_in = 32'h8002_0000; if_size_in = 2'b10;
    for (int k = 0; k < 3; k++) begin
      boot_req_in = 1; boot_addr_in = 32'h8002_0000 + 32'(k);
      boot_data_in = bdata[k]; boot_size_in = 2'b00;
      if (k == 2) boot_done_in = 1;
      wait_for(0, t);
      check("boot_write_strobe", mem_write_out, 1);
      check("boot_stall_held", fetch_stall_out, 1);
      if (k > 0) check("boot_gnt_gap", 32'(t - tprev), 2);
      tprev = t;
    end
    boot_req_in = 0;

    // Boot exit: TURN, then RUN entry edge, then the fetch grant.
    wait_for(1, tf);
    check("first_fetch_delay", 32'(tf - tprev), 3);
    check("stall_dropped", fetch_stall_out, 0);
    check("first_fetch_addr", mem_address_out, 32'h8002_0000);
    if_req_in = 0;
    wait_for(3, tr);
    check("first_fetch_rdata", if_rdata_out, 32'h0000_00AA);

    // Read latency, with a load raised while the fetch is outstanding.
    if_req_in = 1; if_addr_in = 32'h8002_0004;
    wait_for(1, tf);
    if_req_in = 0;
    d_req_in = 1; d_we_in = 0; d_addr_in = 32'h8002_0100; d_size_in = 2'b10;
    wait_for(3, tr);
    check("fetch_rvalid_lat", 32'(tr - tf), 2);
    check("fetch_rdata", if_rdata_out, 32'h27BD_FFE8);
    wait_for(2, td);
    check("load_after_wait", 32'(td - tf), 3);
    d_req_in = 0;
    wait_for(4, tr);
    check("load_rdata", d_rdata_out, 32'hC0DE_0100);

    // Contention: both held high; expect D D D D F D D D D F.
    d_req_in = 1; d_we_in = 1; d_addr_in = 32'h8002_1100; d_wdata_in = 32'h5A5A_0000;
    if_req_in = 1; if_addr_in = 32'h8002_0004;
    pat = '0;
    for (int g = 0; g < 10; g++) begin
      wait_for(5, t);
      pat[g] = if_gnt_out;
    end
    check("starve_pattern", 32'(pat), 32'h0000_0210);
    d_req_in = 0; if_req_in = 0;
    wait_for(3, tr);

    // Store then load to the same word.
    d_req_in = 1; d_we_in = 1; d_addr_in = 32'h8002_1000; d_wdata_in = 32'h1234_5678;
    d_size_in = 2'b10;
    wait_for(2, t);
    check("store_strobe", mem_write_out, 1);
    check("store_data", mem_data_out, 32'h1234_5678);
    d_we_in = 0;
    @(negedge clk);
    check("store_strobe_off", mem_write_out, 0);
    wait_for(2, t);
    d_req_in = 0;
    wait_for(4, tr);
    check("load_back_lat", 32'(tr - t), 2);
    check("load_back_data", d_rdata_out, 32'h1234_5678);

    // Reset in the middle of a fetch read.
    boot_done_in = 0;
    if_req_in = 1; if_addr_in = 32'h8002_0004;
    wait_for(1, tf);
    if_req_in = 0;
    #2 rst_n = 0;
    #1;
    check("midrst_stall", fetch_stall_out, 1);
    check("midrst_addr", mem_address_out, 0);
    check("midrst_size", mem_access_size_out, 0);
    check("midrst_rdata", if_rdata_out, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_rvalid", if_rvalid_out, 0);
    end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_stall", fetch_stall_out, 1);
      check("post_rst_no_rvalid", if_rvalid_out, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
